// File: rtl/switch_entry.sv
// Debounced pushbutton + slide-switch capture, offered downstream on valid/ready.
// Optional autorepeat while held: define SW_ENTRY_AUTOREPEAT_EN.
module switch_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 12500000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic [7:0] sw,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2 ||
      CNT_W < $clog2(DEBOUNCE_CYCLES) ||
      CNT_W < $clog2(REPEAT_CYCLES)) begin : g_bad_param
    $error("switch_entry: DEBOUNCE_CYCLES/REPEAT_CYCLES/CNT_W out of range");
  end

  logic       key_m, key_s;
  logic [7:0] sw_m, sw_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      key_m <= key_n;
      key_s <= key_m;
      sw_m  <= sw;
      sw_s  <= sw_m;
    end
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             cap_key, rpt_fire, cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap_key  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!key_s) begin
          cnt_nx   = ONE;
          state_nx = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt == DB_LAST) begin
          cap_key  = 1'b1;
          cnt_nx   = '0;
          state_nx = HELD;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      HELD: begin
        if (key_s) begin
          cnt_nx   = ONE;
          state_nx = REL_WAIT;
        end
      end
      REL_WAIT: begin
        if (!key_s) begin
          cnt_nx   = '0;
          state_nx = HELD;
        end else if (cnt == DB_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

`ifdef SW_ENTRY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rpt, rpt_nx;

  // Runs only while staying in HELD, so entry and exit both clear it.
  always_comb begin
    rpt_nx   = '0;
    rpt_fire = 1'b0;
    if (state == HELD && state_nx == HELD && !key_s) begin
      if (rpt == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_nx = rpt + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt <= '0;
    end else begin
      rpt <= rpt_nx;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign cap = cap_key | rpt_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      data        <= '0;
      valid       <= 1'b0;
      overrun     <= 1'b0;
      press_count <= '0;
    end else begin
      if (cap) begin
        press_count <= press_count + 8'd1;
        if (!valid || ready) begin
          data  <= sw_s;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_entry.sv
// Directed bench for switch_entry with short debounce/repeat periods.
module tb_switch_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic [7:0] sw;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       overrun;
  logic [7:0] press_count;

  int n_chk  = 0;
  int n_fail = 0;
  int n_hi;

  switch_entry #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .sw         (sw),
    .ready      (ready),
    .data       (data),
    .valid      (valid),
    .overrun    (overrun),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    key_n = 1'b1;
    rst   = 1'b1;
    tick(2);
    rst   = 1'b0;
  endtask

  task automatic press(input logic [7:0] v);
    sw    = v;
    key_n = 1'b0;
    tick(6);
    key_n = 1'b1;
    tick(8);
  endtask

  initial begin
    rst   = 1'b1;
    key_n = 1'b1;
    sw    = 8'h00;
    ready = 1'b0;
    tick(2);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_count", 32'(press_count), 32'd0);
    rst = 1'b0;

    // clean press latency
    sw    = 8'hA5;
    key_n = 1'b0;
    tick(5);
    chk("lat_edge5_valid", 32'(valid), 32'd0);
    tick(1);
    chk("lat_edge6_valid", 32'(valid), 32'd1);
    chk("lat_data", 32'(data), 32'hA5);
    chk("lat_count", 32'(press_count), 32'd1);
    key_n = 1'b1;
    tick(8);

    // glitchy key never confirms
    do_reset();
    for (int i = 0; i < 20; i++) begin
      key_n = (i % 3 == 2);
      tick(1);
    end
    key_n = 1'b1;
    tick(8);
    chk("glitch_valid", 32'(valid), 32'd0);
    chk("glitch_count", 32'(press_count), 32'd0);

    // overrun with ready low
    press(8'h12);
    chk("ovr_first_valid", 32'(valid), 32'd1);
    chk("ovr_first_data", 32'(data), 32'h12);
    press(8'h34);
    chk("ovr_data", 32'(data), 32'h12);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(press_count), 32'd2);
    chk("ovr_valid_held", 32'(valid), 32'd1);
    ready = 1'b1;
    tick(1);
    chk("ovr_valid_drop", 32'(valid), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // single-cycle valid, release bounce
    do_reset();
    chk("rst_clears_ovr", 32'(overrun), 32'd0);
    ready = 1'b1;
    sw    = 8'h7F;
    key_n = 1'b0;
    tick(6);
    chk("rdy_valid", 32'(valid), 32'd1);
    chk("rdy_data", 32'(data), 32'h7F);
    n_hi = 0;
    tick(1);
    n_hi += int'(valid);
    key_n = 1'b1;
    tick(1);
    n_hi += int'(valid);
    key_n = 1'b0;
    tick(1);
    n_hi += int'(valid);
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n_hi += int'(valid);
    end
    chk("bounce_extra_valid", 32'(n_hi), 32'd0);
    chk("bounce_count", 32'(press_count), 32'd1);

    // switch sampled two edges before capture
    sw    = 8'h3C;
    key_n = 1'b0;
    tick(4);
    sw = 8'hC3;
    tick(2);
    chk("sw_sample_data", 32'(data), 32'h3C);
    key_n = 1'b1;
    tick(8);
    chk("sw_sample_count", 32'(press_count), 32'd2);

    // wrap after 256 presses
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 256; i++) press(8'(i));
    chk("wrap_count", 32'(press_count), 32'h00);
    chk("wrap_overrun", 32'(overrun), 32'd0);
    chk("wrap_data", 32'(data), 32'hFF);
    chk("wrap_valid", 32'(valid), 32'd0);

    // reset in PRESS_WAIT with valid pending, key still held
    ready = 1'b0;
    press(8'h55);
    sw    = 8'h66;
    key_n = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_data", 32'(data), 32'h00);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_count", 32'(press_count), 32'd0);
    rst = 1'b0;
    tick(5);
    chk("held_after_rst_wait", 32'(valid), 32'd0);
    tick(1);
    chk("held_after_rst_valid", 32'(valid), 32'd1);
    chk("held_after_rst_data", 32'(data), 32'h66);
    chk("held_after_rst_count", 32'(press_count), 32'd1);
    key_n = 1'b1;
    tick(8);

    // held key: autorepeat or not
    do_reset();
    ready = 1'b1;
    sw    = 8'h01;
    key_n = 1'b0;
    n_hi  = 0;
    for (int i = 0; i < 36; i++) begin
      tick(1);
      n_hi += int'(valid);
    end
`ifdef SW_ENTRY_AUTOREPEAT_EN
    chk("repeat_count", 32'(press_count), 32'd4);
    chk("repeat_valid_cycles", 32'(n_hi), 32'd4);
`else
    chk("repeat_count", 32'(press_count), 32'd1);
    chk("repeat_valid_cycles", 32'(n_hi), 32'd1);
`endif
    chk("repeat_data", 32'(data), 32'h01);
    key_n = 1'b1;
    tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_entry.md
# switch_entry

Input-side front end for the board's operand-entry path: it turns a raw, bouncing, active-low pushbutton and the raw 8-bit slide switches into clean, single-shot data transfers for the accumulator datapath. Both inputs are synchronised and the key is debounced in both directions. On each confirmed press the switch value is captured and offered downstream over a valid/ready handshake. It is the counterpart of the seven-segment output path: it drives the accumulator from the board instead of reading the accumulator out to the board.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to confirm a press or a release (10 ms at 50 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, default 12500000: autorepeat period; used only when autorepeat is compiled in.
- `CNT_W`, default 25: counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES).
- `clk` in 1: single clock; every flop is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_n` in 1: raw pushbutton, active-low, asynchronous.
- `sw` in 8: raw slide switches, asynchronous.
- `ready` in 1: downstream accepts `data` in any cycle where `valid && ready`.
- `data` out 8: captured switch value.
- `valid` out 1: `data` is pending.
- `overrun` out 1: sticky flag; a press was dropped because the previous value was still pending.
- `press_count` out 8: number of confirmed captures, modulo 256.

## Operation
- Synchronisers: 2-flop chains on `key_n` and on each `sw` bit, giving `key_s` and `sw_s`. There is no debounce on `sw`; the value is sampled at capture time.
- FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT; one shared counter `cnt`.
  - IDLE: when `key_s`=0, set `cnt`=1 and go to PRESS_WAIT.
  - PRESS_WAIT, `key_s`=1 (bounce): go to IDLE and clear `cnt`.
  - PRESS_WAIT, `key_s`=0 and `cnt`==DEBOUNCE_CYCLES-1: capture, go to HELD, clear `cnt`.
  - PRESS_WAIT, otherwise: `cnt`++.
  - HELD: when `key_s`=1, set `cnt`=1 and go to REL_WAIT.
  - REL_WAIT, `key_s`=0 (bounce): go to HELD with no new capture.
  - REL_WAIT, `cnt`==DEBOUNCE_CYCLES-1 with `key_s`=1: go to IDLE.
  - REL_WAIT, otherwise: `cnt`++.
- Capture event:
  - If `valid`=0, or `valid && ready` in the same cycle: `data`←`sw_s`, `valid`←1.
  - Otherwise (`valid && !ready`): `data` is unchanged and `overrun`←1.
  - `press_count` increments on every capture event, including dropped ones, and wraps 255→0.
- Handshake:
  - `valid`, once high, stays high and `data` stays stable until a cycle with `ready`=1.
  - `valid` then drops on the next edge, unless a capture occurs in that same cycle.
  - `ready` is ignored while `valid`=0.
- `overrun` clears only on `rst`.

## Timing
- Reset values: `data`=0x00, `valid`=0, `overrun`=0, `press_count`=0, FSM=IDLE, `cnt`=0.
  - `key_n` synchroniser flops reset to 1 (released); `sw` synchroniser flops reset to 0.
- Press latency: with `key_n` low from edge 0 and no bounce, `key_s` is low after edge 2. `valid` is high after edge DEBOUNCE_CYCLES+2.
- `data` equals `sw` as sampled 2 edges before the capture edge.
- Release is confirmed after DEBOUNCE_CYCLES stable-high cycles of `key_s`. A new press can only start after release is confirmed.
- Any single-cycle glitch restarts the debounce count from the current state. A glitch never produces a capture.
- Reset mid-operation (any state, `valid` pending) returns everything to reset values on that edge.
  - A key still held after reset is treated as a new press and produces one capture after debounce.
- Throughput: at most one capture per press without autorepeat. The handshake itself adds no bubble.

## Configuration
- `SW_ENTRY_AUTOREPEAT_EN`, defined: autorepeat is compiled in.
  - In HELD with `key_s`=0, a second counter counts to REPEAT_CYCLES.
  - Each time it wraps, a further capture event fires, following the same capture and overrun rules.
  - The repeat counter is cleared on entering HELD, leaving HELD, and on `rst`.
- Not defined: no repeat logic; a held key yields exactly one capture. REPEAT_CYCLES is ignored.

## Test plan
Benches use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, CNT_W=4.
- Reset, then `sw`=0xA5 and `key_n` held low → `valid`=1 and `data`=0xA5 after edge 6; `press_count`=1.
- `key_n` low with 1-cycle high glitches every 3 cycles for 20 cycles → `valid` stays 0 and `press_count`=0.
- With `ready`=0: press 0x12, release, press 0x34 → `data`=0x12, `overrun`=1, `press_count`=2. Raise `ready` → `valid` drops the next edge.
- `ready`=1 held: press 0x7F → `valid` high for exactly 1 cycle. Release bounce 0→1→0→1 produces no second capture.
- 256 clean presses with `ready`=1 → `press_count` wraps to 0x00 and `overrun`=0. Assert `rst` during PRESS_WAIT → all outputs return to reset values.
- With `SW_ENTRY_AUTOREPEAT_EN` defined, `ready`=1, key held 30 cycles past confirm, `sw`=0x01 → 1 initial plus 3 repeat captures, `press_count`=4. Without the macro → `press_count`=1.
